if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage of the RISC-V pipeline. Produces the in_instr/in_pc/valid stream consumed by the IF/ID register.
//  Drives a req/gnt/rvalid instruction-memory port and buffers returned words in a small prefetch FIFO.
//  Handles stalls from ID and redirects from branch/jump resolution; a redirect is the same event that flushes IF/ID.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset; bits [1:0] must be 0
//  DEPTH       2              prefetch FIFO entries = max in-flight + buffered words (power of 2, >=2)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   asynchronous reset, active low
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address, word aligned
//  imem_gnt     in   1   request accepted this cycle (req & gnt = issue)
//  imem_rvalid  in   1   read data valid; responses return in issue order, >=1 cycle after issue
//  imem_rdata   in   32  instruction word
//  redirect     in   1   discard the current path and restart at redirect_pc
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  stall        in   1   ID cannot accept; hold the current output
//  out_instr    out  32  instruction to IF/ID
//  out_pc       out  32  PC of out_instr
//  out_valid    out  1   out_instr/out_pc valid and consumed this cycle
// BEHAVIOUR
//  State: fetch_pc[31:0], FIFO of {pc,instr} x DEPTH, pc_q FIFO of issued PCs, inflight cnt, discard cnt.
//  Reset (reset_n low, async): fetch_pc=RESET_PC, FIFOs empty, inflight=0, discard=0.
//    All outputs are 0 while reset_n is low: imem_req, imem_addr, out_instr, out_pc, out_valid.
//  Issue: imem_req = ~redirect & (inflight + fifo_count < DEPTH); imem_addr = fetch_pc.
//    On req&gnt: push fetch_pc to pc_q; inflight++; fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
//    While req=1 and gnt=0, imem_addr is held stable (no redirect that cycle).
//  Response: rvalid with discard>0 -> word dropped, discard--, inflight--, pc_q pop.
//    rvalid with discard=0 -> push {pc_q head, rdata} into FIFO; inflight--, pc_q pop.
//    rvalid with inflight=0 is a protocol error; it is ignored (assertion in bench).
//  Output: out_valid = fifo_nonempty & ~stall & ~redirect; out_instr/out_pc = FIFO head when out_valid, else 0.
//    Pop when out_valid=1. Latency: response cycle -> out_valid on the next cycle at the earliest (registered FIFO).
//    A FIFO push and pop in the same cycle are allowed; credit rule guarantees no overflow.
//  Redirect (highest priority, single cycle):
//    FIFO cleared; fetch_pc <= {redirect_pc[31:2],2'b00}; imem_req forced 0 that cycle.
//    discard <= inflight minus 1 if rvalid that cycle (that response is dropped); pc_q entries retained
//      for discard accounting.
//    Redirect overrides stall; back-to-back redirects: the last one wins and discard accumulates correctly.
//  Stall: FIFO holds; issue continues until credit is exhausted; no word is lost or duplicated.
//  Counter widths: inflight/discard use clog2(DEPTH)+1 bits and never exceed DEPTH.
// TESTING
//  T1 RESET_PC=32'h8000_0000, gnt=1, rvalid 1 cycle later -> out_pc 8000_0000, 8000_0004, 8000_0008 with matching instrs.
//  T2 stall=1 for 6 cycles mid-stream -> out_valid=0, imem_req drops after DEPTH words held;
//     on release, stream resumes in order with no gaps or duplicates.
//  T3 2 words in flight, redirect_pc=32'h0000_0100 -> both late responses dropped; next out_pc=0x100.
//  T4 redirect_pc=32'h0000_0103 coincident with rvalid and stall=1 -> rvalid word dropped,
//     out_valid=0 that cycle, next fetch addr 0x100.
//  T5 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  T6 reset_n asserted with FIFO full and 2 in flight -> all outputs 0 immediately;
//     after release, fetch restarts at RESET_PC with empty state.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/stall from
// later stages and the instruction stream handed to IF/ID.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;

  modport master (
    output imem_req, imem_addr, out_instr, out_pc, out_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, out_instr, out_pc, out_valid,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Issues word fetches on a req/gnt/rvalid port,
// tags returning words with their PC and buffers them in a small prefetch
// FIFO. Credit (in-flight + buffered <= DEPTH) bounds the FIFO. A redirect
// flushes the buffer and marks every outstanding fetch for discard.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic        clk,
  input logic        reset_n,
  if_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_pc_d [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic [AW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [31:0]   pcq_q [DEPTH];
  logic [31:0]   pcq_d [DEPTH];
  logic [AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW:0]   credit_used;
  logic          req, issue, resp, keep, out_valid;

  // Handshake decode: credit check, issue, response classification, output pop.
  always_comb begin
    credit_used = {1'b0, inflight_q} + {1'b0, buf_cnt_q};
    req         = reset_n & ~bus.redirect & (credit_used < DEPTH_W);
    issue       = req & bus.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp        = bus.imem_rvalid & (inflight_q != '0);
    // The response coinciding with a redirect belongs to the old path.
    keep        = resp & (discard_q == '0) & ~bus.redirect;
    out_valid   = (buf_cnt_q != '0) & ~bus.stall & ~bus.redirect;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = reset_n ? fetch_pc_q : 32'h0;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? buf_pc_q[buf_rd_q]    : 32'h0;
  assign bus.out_instr = out_valid ? buf_instr_q[buf_rd_q] : 32'h0;

  // Next-state for fetch PC, issued-PC queue, counters and prefetch FIFO.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pcq_d       = pcq_q;
    pcq_wr_d    = pcq_wr_q;
    pcq_rd_d    = pcq_rd_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_wr_d    = buf_wr_q;
    buf_rd_d    = buf_rd_q;
    buf_cnt_d   = buf_cnt_q;
    inflight_d  = inflight_q + CW'(issue) - CW'(resp);
    discard_d   = discard_q;

    if (issue) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = pcq_wr_q + 1'b1;
    end
    // Issued PCs stay queued across redirects so dropped words still pop them.
    if (resp) begin
      pcq_rd_d = pcq_rd_q + 1'b1;
    end

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      discard_d  = inflight_q - CW'(resp);
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      buf_cnt_d  = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if (keep) begin
        buf_pc_d[buf_wr_q]    = pcq_q[pcq_rd_q];
        buf_instr_d[buf_wr_q] = bus.imem_rdata;
        buf_wr_d              = buf_wr_q + 1'b1;
      end
      if (out_valid) begin
        buf_rd_d = buf_rd_q + 1'b1;
      end
      buf_cnt_d = buf_cnt_q + CW'(keep) - CW'(out_valid);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_cnt_q   <= buf_cnt_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      pcq_q       <= pcq_d;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: random memory latency, stalls and redirects. The
// reference is the architectural stream: consecutive PCs from the last
// reset/redirect target, each carrying the memory word at that address.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_cyc_q[$];
  logic [31:0] path_pc;
  logic [31:0] next_issue;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_pc_q.size() < 16) begin
      exp_pc_q.push_back(path_pc);
      exp_ins_q.push_back(ins_of(path_pc));
      path_pc = path_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_pc_q.delete();
    exp_ins_q.delete();
    path_pc    = pc;
    next_issue = pc;
    topup();
  endtask

  // One cycle of stimulus; the memory answers the oldest request no earlier
  // than the cycle after it was issued.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input int gnt_pct, input int rv_pct);
    logic [31:0] a;
    @(negedge clk);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_gnt    = (int'($urandom_range(99)) < gnt_pct);
    if (pend_addr_q.size() > 0 && pend_cyc_q[0] < cyc &&
        int'($urandom_range(99)) < rv_pct) begin
      a = pend_addr_q.pop_front();
      void'(pend_cyc_q.pop_front());
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ins_of(a);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    if (rd) model_restart(rpc & 32'hFFFF_FFFC);
    topup();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},   {31'b0, bus.imem_req},  32'h0);
    chk({tag, "_addr"},  bus.imem_addr,          32'h0);
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'h0);
    chk({tag, "_pc"},    bus.out_pc,             32'h0);
    chk({tag, "_instr"}, bus.out_instr,          32'h0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b0;
    bus.stall       = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("rst_async");
    pend_addr_q.delete();
    pend_cyc_q.delete();
    repeat (hold) @(negedge clk);
    chk_outputs_zero("rst_hold");
    reset_n = 1'b1;
    model_restart(RESET_PC);
  endtask

  // Monitor: protocol checks, issue tracking and scoreboard comparison.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (bus.redirect) chk("req_on_redirect", {31'b0, bus.imem_req}, 32'h0);
      if (bus.stall || bus.redirect) chk("valid_blocked", {31'b0, bus.out_valid}, 32'h0);
      if (prev_wait && !bus.redirect) chk("addr_hold", bus.imem_addr, prev_addr);
      if (bus.imem_req) begin
        chk("issue_addr", bus.imem_addr, next_issue);
        if (bus.imem_gnt) begin
          pend_addr_q.push_back(bus.imem_addr);
          pend_cyc_q.push_back(cyc);
          next_issue = bus.imem_addr + 32'd4;
        end
      end
      chk("credit_bound", {31'b0, pend_addr_q.size() <= DEPTH}, 32'h1);
      if (bus.out_valid) begin
        out_cnt++;
        if (exp_pc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got pc %h expected no output", bus.out_pc);
        end else begin
          chk("out_pc",    bus.out_pc,    exp_pc_q.pop_front());
          chk("out_instr", bus.out_instr, exp_ins_q.pop_front());
        end
      end else begin
        chk("idle_zero", bus.out_pc | bus.out_instr, 32'h0);
      end
      prev_wait = bus.imem_req & ~bus.imem_gnt;
      prev_addr = bus.imem_addr;
    end else begin
      prev_wait = 1'b0;
    end
  end

  initial begin
    int c0;
    bit st_state;
    logic [31:0] rpc;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.stall       = 1'b0;

    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_restart(RESET_PC);

    // Straight-line fetch across the address wrap.
    repeat (10) step(1'b0, 1'b0, '0, 100, 100);

    // Long stall: credit runs out and requests stop.
    repeat (12) step(1'b1, 1'b0, '0, 100, 100);
    #2;
    chk("stall_req_drop", {31'b0, bus.imem_req}, 32'h0);
    chk("stall_valid",    {31'b0, bus.out_valid}, 32'h0);
    repeat (10) step(1'b0, 1'b0, '0, 100, 100);

    // Full FIFO then asynchronous reset.
    repeat (12) step(1'b1, 1'b0, '0, 100, 100);
    do_reset(2);

    // Two fetches in flight, then redirect: both late words must vanish.
    repeat (2) step(1'b0, 1'b0, '0, 100, 0);
    step(1'b0, 1'b1, 32'h0000_0100, 100, 0);
    repeat (10) step(1'b0, 1'b0, '0, 100, 100);

    // Misaligned redirect coinciding with a response and a stall.
    repeat (3) step(1'b1, 1'b0, '0, 100, 0);
    step(1'b1, 1'b1, 32'h0000_0103, 100, 100);
    repeat (10) step(1'b0, 1'b0, '0, 100, 100);

    // Randomised traffic.
    st_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset(1 + (i / 1000));
      if (int'($urandom_range(99)) < 15) st_state = ~st_state;
      if (int'($urandom_range(99)) < 4) begin
        case ($urandom_range(3))
          0: rpc = $urandom;
          1: rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
          2: rpc = 32'h0000_0100 + 32'($urandom_range(15));
          default: rpc = {$urandom_range(255), 8'h00} + 32'($urandom_range(3));
        endcase
        step(st_state, 1'b1, rpc, 75, 70);
      end else begin
        step(st_state, 1'b0, '0, 75, 70);
      end
    end

    // Drain: with no stalls the stream must keep flowing.
    c0 = out_cnt;
    repeat (40) step(1'b0, 1'b0, '0, 100, 100);
    chk("drain_progress", {31'b0, (out_cnt - c0) >= 20}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
